env_step_sequencer: RTL and testbench
=====================================

Name: env_step_sequencer

Overview:
- Controller that sequences the traffic environment block (ENV) through Q-learning steps: action fetch, environment advance, settle, observe, experience hand-off.
- Sits between the agent/action selector and the learning (Q-update) unit; it is the only driver of ENV's action, mode and advance controls.
- Counts steps per episode and episodes per run, and resets ENV lane state at each episode boundary.

Parameters:
- L_WIDTH, 4, lane-count width; matches ENV.
- R_WIDTH, 16, signed reward width; matches ENV.
- A_WIDTH, L_WIDTH/2+2, action width.
- S_WIDTH, L_WIDTH*2, state width.
- STEP_MAX, 16, steps per episode; must be at least 1.
- EP_MAX, 8, episodes per run; must be at least 1.
- HOLD_CYCLES, 3, settle cycles after each ENV advance; must be at least 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; acted on only in IDLE or DONE.
- abort  in  1  synchronous run abort.
- cfg_mode  in  1  ENV mode for the run (1 = simulated state); latched at start.
- act_valid  in  1  agent action valid.
- act_data  in  A_WIDTH  agent action.
- act_ready  out  1  sequencer accepts action.
- env_S  in  S_WIDTH  ENV state output.
- env_R  in  R_WIDTH  ENV reward, signed.
- env_A  out  A_WIDTH  action driven to ENV.
- env_mode  out  1  mode driven to ENV.
- env_en  out  1  one-cycle ENV advance strobe.
- env_rst  out  1  one-cycle ENV lane-state clear.
- xp_valid  out  1  experience tuple valid.
- xp_ready  in  1  learning unit accepts tuple.
- xp_s  out  S_WIDTH  state before action.
- xp_a  out  A_WIDTH  action taken.
- xp_r  out  R_WIDTH  reward, signed.
- xp_s_next  out  S_WIDTH  state after action.
- xp_last  out  1  tuple is the final step of its episode.
- step_cnt  out  $clog2(STEP_MAX)  current step index.
- ep_cnt  out  $clog2(EP_MAX)  current episode index.
- busy  out  1  1 in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0, including counters and xp_* data.
- States: IDLE, REQ_ACT, APPLY, HOLD, SAMPLE, PUBLISH, DONE.
- IDLE / DONE, on start=1:
  - Latch cfg_mode into env_mode; clear step_cnt and ep_cnt.
  - Pulse env_rst for 1 cycle; go to REQ_ACT.
  - done drops on leaving DONE.
- REQ_ACT:
  - act_ready=1.
  - On act_valid & act_ready (cycle t): latch act_data into env_A and xp_a, latch env_S into xp_s, go to APPLY.
- APPLY (cycle t+1): env_en=1 for exactly one cycle; load hold counter with HOLD_CYCLES-1; go to HOLD.
- HOLD: decrement the counter; leave for SAMPLE when it reads 0. HOLD lasts exactly HOLD_CYCLES cycles (t+2 .. t+1+HOLD_CYCLES).
- SAMPLE (t+2+HOLD_CYCLES):
  - Latch env_S into xp_s_next and env_R into xp_r.
  - Set xp_last=(step_cnt==STEP_MAX-1); go to PUBLISH.
- PUBLISH:
  - xp_valid=1; all xp_* fields held stable until xp_valid & xp_ready.
  - Not last step (handshake cycle): step_cnt+1, go to REQ_ACT.
  - Last step, not last episode (handshake cycle): step_cnt=0, ep_cnt+1, env_rst pulse in the following cycle (in REQ_ACT), go to REQ_ACT.
  - Last step of last episode (ep_cnt==EP_MAX-1): go to DONE; ep_cnt and step_cnt hold their final values.
- Tuple-to-action latency:
  - Earliest env_en is 1 cycle after the action handshake.
  - Earliest xp_valid is HOLD_CYCLES+3 cycles after the action handshake.
- env_en and env_rst are never asserted in the same cycle.
- env_A and env_mode hold their values between strobes.
- abort:
  - Effective in any state; next state is IDLE.
  - xp_valid, act_ready and env_en are 0 in the cycle after.
  - Counters clear; env_mode holds.
  - abort in the same cycle as a handshake: abort wins; no counter update.
- start while busy: ignored.
- rst mid-operation: identical to the reset state; no env_rst pulse is issued.
- Reward passes through unmodified (signed, R_WIDTH); the sequencer performs no arithmetic on it.

Test Plan:
- Nominal step (HOLD_CYCLES=3):
  - Stimulus: start; act handshake with act_data=4'h5 at cycle t; env_S=8'h21 at t, 8'h34 at t+5; env_R=-3.
  - Required: env_en pulse at t+1; xp_valid at t+6 with s=21, a=5, r=FFFD, s_next=34, xp_last=0.
- Episode wrap (STEP_MAX=2, EP_MAX=2), xp_ready always 1:
  - Required: xp_last on steps 1 and 3; env_rst pulses at start and after tuple 2; done after tuple 4; exactly 4 env_en pulses.
- Backpressure: hold xp_ready=0 for 5 cycles in PUBLISH while changing env_S/env_R -> xp_* unchanged, xp_valid stays 1, act_ready=0, step_cnt unchanged.
- Agent stall: act_valid=0 for 10 cycles in REQ_ACT -> act_ready stays 1, no env_en, counters frozen.
- Abort in HOLD, then abort coincident with an xp handshake -> both return to IDLE next cycle; no further env_en; step_cnt=0; busy=0.
- Reset mid-run: rst=1 for 1 cycle during PUBLISH -> all outputs 0 next cycle; start afterward restarts from step 0 / episode 0 with env_rst pulse and env_mode = newly latched cfg_mode.

Source files
------------

// File: rtl/env_step_sequencer.sv
// env_step_sequencer: sequences ENV through Q-learning steps and hands experience tuples to the learner
module env_step_sequencer #(
  parameter int L_WIDTH = 4,
  parameter int R_WIDTH = 16,
  parameter int A_WIDTH = L_WIDTH/2+2,
  parameter int S_WIDTH = L_WIDTH*2,
  parameter int STEP_MAX = 16,
  parameter int EP_MAX = 8,
  parameter int HOLD_CYCLES = 3,
  localparam int SC_W = STEP_MAX > 1 ? $clog2(STEP_MAX) : 1,
  localparam int EC_W = EP_MAX > 1 ? $clog2(EP_MAX) : 1,
  localparam int HC_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_mode,
  input  logic               act_valid,
  input  logic [A_WIDTH-1:0] act_data,
  output logic               act_ready,
  input  logic [S_WIDTH-1:0] env_S,
  input  logic [R_WIDTH-1:0] env_R,
  output logic [A_WIDTH-1:0] env_A,
  output logic               env_mode,
  output logic               env_en,
  output logic               env_rst,
  output logic               xp_valid,
  input  logic               xp_ready,
  output logic [S_WIDTH-1:0] xp_s,
  output logic [A_WIDTH-1:0] xp_a,
  output logic [R_WIDTH-1:0] xp_r,
  output logic [S_WIDTH-1:0] xp_s_next,
  output logic               xp_last,
  output logic [SC_W-1:0]    step_cnt,
  output logic [EC_W-1:0]    ep_cnt,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, REQ_ACT, APPLY, HOLD, SAMPLE, PUBLISH, DONE} state_t;
  state_t state_q, state_d;
  logic [SC_W-1:0] step_q, step_d;
  logic [EC_W-1:0] ep_q, ep_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic mode_q, mode_d, erst_q, erst_d, last_q, last_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [S_WIDTH-1:0] s_q, s_d, sn_q, sn_d;
  logic [R_WIDTH-1:0] r_q, r_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= '0;
      ep_q <= '0;
      hold_q <= '0;
      mode_q <= 1'b0;
      erst_q <= 1'b0;
      last_q <= 1'b0;
      a_q <= '0;
      s_q <= '0;
      sn_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      ep_q <= ep_d;
      hold_q <= hold_d;
      mode_q <= mode_d;
      erst_q <= erst_d;
      last_q <= last_d;
      a_q <= a_d;
      s_q <= s_d;
      sn_q <= sn_d;
      r_q <= r_d;
    end
  end
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    ep_d = ep_q;
    hold_d = hold_q;
    mode_d = mode_q;
    erst_d = 1'b0;
    last_d = last_q;
    a_d = a_q;
    s_d = s_q;
    sn_d = sn_q;
    r_d = r_q;
    if (abort) begin
      state_d = IDLE;
      step_d = '0;
      ep_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          mode_d = cfg_mode;
          step_d = '0;
          ep_d = '0;
          erst_d = 1'b1;
          state_d = REQ_ACT;
        end
        REQ_ACT: if (act_valid) begin
          a_d = act_data;
          s_d = env_S;
          state_d = APPLY;
        end
        APPLY: begin
          hold_d = HC_W'(HOLD_CYCLES-1);
          state_d = HOLD;
        end
        HOLD: begin
          hold_d = hold_q - HC_W'(1);
          state_d = hold_q == '0 ? SAMPLE : HOLD;
        end
        SAMPLE: begin
          sn_d = env_S;
          r_d = env_R;
          last_d = step_q == SC_W'(STEP_MAX-1);
          state_d = PUBLISH;
        end
        PUBLISH: if (xp_ready) begin
          if (!last_q) begin
            step_d = step_q + SC_W'(1);
            state_d = REQ_ACT;
          end else if (ep_q != EC_W'(EP_MAX-1)) begin
            step_d = '0;
            ep_d = ep_q + EC_W'(1);
            erst_d = 1'b1;
            state_d = REQ_ACT;
          end else begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign act_ready = state_q == REQ_ACT;
  assign env_en = state_q == APPLY;
  assign xp_valid = state_q == PUBLISH;
  assign done = state_q == DONE;
  assign busy = !(state_q == IDLE || state_q == DONE);
  assign env_rst = erst_q;
  assign env_mode = mode_q;
  assign env_A = a_q;
  assign xp_a = a_q;
  assign xp_s = s_q;
  assign xp_s_next = sn_q;
  assign xp_r = r_q;
  assign xp_last = last_q;
  assign step_cnt = step_q;
  assign ep_cnt = ep_q;
endmodule

// File: tb/tb_env_step_sequencer.sv
// tb_env_step_sequencer: directed scenarios plus randomized runs checked against a transaction-level model
module tb_env_step_sequencer;
  localparam int A = 4, S = 8, R = 16, SM = 2, EM = 2, H = 3;
  logic clk = 1'b0;
  logic rst, start, abort, cfg_mode, act_valid, act_ready, env_mode, env_en, env_rst;
  logic xp_valid, xp_ready, xp_last, busy, done;
  logic [A-1:0] act_data, env_A, xp_a;
  logic [S-1:0] env_S, xp_s, xp_s_next;
  logic [R-1:0] env_R, xp_r;
  logic [0:0] step_cnt, ep_cnt;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  env_step_sequencer #(.L_WIDTH(4), .R_WIDTH(R), .STEP_MAX(SM), .EP_MAX(EM), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .env_S(env_S), .env_R(env_R), .env_A(env_A), .env_mode(env_mode), .env_en(env_en), .env_rst(env_rst),
    .xp_valid(xp_valid), .xp_ready(xp_ready), .xp_s(xp_s), .xp_a(xp_a), .xp_r(xp_r),
    .xp_s_next(xp_s_next), .xp_last(xp_last), .step_cnt(step_cnt), .ep_cnt(ep_cnt), .busy(busy), .done(done)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] outs();
    return {act_ready, env_en, env_rst, xp_valid, xp_last, busy, done, env_mode, env_A, xp_a, xp_s, xp_s_next, xp_r, step_cnt, ep_cnt};
  endfunction
  task automatic test_reset;
    rst = 1; start = 1; abort = 0; cfg_mode = 1; act_valid = 1; act_data = 4'($urandom);
    env_S = 8'($urandom); env_R = 16'($urandom); xp_ready = 1;
    tick;
    tick;
    n_tests++;
    if (outs() !== 64'd0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", outs()); end
    rst = 0; start = 0; act_valid = 0; xp_ready = 0;
    tick;
    n_tests++;
    if ({busy, env_rst, act_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_idle got=%b want=000", {busy, env_rst, act_ready}); end
  endtask
  task automatic test_nominal;
    cfg_mode = 1; start = 1;
    tick;
    start = 0;
    n_tests++;
    if ({env_rst, env_mode, act_ready, busy, done} !== 5'b11110) begin n_fail++; $display("FAIL nominal_start got=%b want=11110", {env_rst, env_mode, act_ready, busy, done}); end
    act_valid = 1; act_data = 4'h5; env_S = 8'h21; env_R = 16'($urandom);
    tick;
    act_valid = 0;
    n_tests++;
    if ({env_en, act_ready, env_rst, env_A} !== {3'b100, 4'h5}) begin n_fail++; $display("FAIL nominal_env_en got=%b want=1000101", {env_en, act_ready, env_rst, env_A}); end
    env_S = 8'($urandom); env_R = 16'($urandom);
    for (int i = 2; i <= 5; i++) begin
      tick;
      n_tests++;
      if ({env_en, xp_valid} !== 2'b00) begin n_fail++; $display("FAIL nominal_wait t+%0d got=%b want=00", i, {env_en, xp_valid}); end
      env_S = i == 5 ? 8'h34 : 8'($urandom);
      env_R = i == 5 ? 16'hFFFD : 16'($urandom);
    end
    tick;
    n_tests++;
    if ({xp_valid, xp_s, xp_a, xp_r, xp_s_next, xp_last, step_cnt} !== {1'b1, 8'h21, 4'h5, 16'hFFFD, 8'h34, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL nominal_tuple got=%h want=%h", {xp_valid, xp_s, xp_a, xp_r, xp_s_next, xp_last, step_cnt}, {1'b1, 8'h21, 4'h5, 16'hFFFD, 8'h34, 1'b0, 1'b0}); end
  endtask
  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      env_S = 8'($urandom); env_R = 16'($urandom); xp_ready = 0;
      tick;
      n_tests++;
      if ({xp_valid, act_ready, step_cnt, xp_s, xp_a, xp_r, xp_s_next, xp_last} !== {3'b100, 8'h21, 4'h5, 16'hFFFD, 8'h34, 1'b0})
        begin n_fail++; $display("FAIL backpressure_hold cyc=%0d got=%h", i, {xp_valid, act_ready, step_cnt, xp_s, xp_a, xp_r, xp_s_next, xp_last}); end
    end
    xp_ready = 1;
    tick;
    xp_ready = 0;
    n_tests++;
    if ({xp_valid, act_ready, step_cnt, ep_cnt, env_rst} !== 5'b01100) begin n_fail++; $display("FAIL backpressure_release got=%b want=01100", {xp_valid, act_ready, step_cnt, ep_cnt, env_rst}); end
  endtask
  task automatic test_stall;
    act_valid = 0;
    for (int i = 0; i < 10; i++) begin
      start = i == 4;
      env_S = 8'($urandom);
      tick;
      n_tests++;
      if ({act_ready, env_en, env_rst, step_cnt, ep_cnt, busy} !== 6'b100101) begin n_fail++; $display("FAIL stall cyc=%0d got=%b want=100101", i, {act_ready, env_en, env_rst, step_cnt, ep_cnt, busy}); end
    end
    start = 0;
  endtask
  task automatic test_abort;
    act_valid = 1; act_data = 4'($urandom);
    tick;
    act_valid = 0;
    tick;
    abort = 1;
    tick;
    abort = 0;
    n_tests++;
    if ({busy, act_ready, env_en, xp_valid, step_cnt, ep_cnt, env_mode} !== 7'b0000001) begin n_fail++; $display("FAIL abort_hold got=%b want=0000001", {busy, act_ready, env_en, xp_valid, step_cnt, ep_cnt, env_mode}); end
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++;
      if ({env_en, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_quiet cyc=%0d got=%b want=00", i, {env_en, busy}); end
    end
    cfg_mode = 1; start = 1;
    tick;
    start = 0; act_valid = 1; act_data = 4'($urandom);
    tick;
    act_valid = 0;
    for (int i = 0; i < 20 && !xp_valid; i++) tick;
    n_tests++;
    if (xp_valid !== 1'b1) begin n_fail++; $display("FAIL abort_reach_publish got=%b want=1", xp_valid); end
    xp_ready = 1; abort = 1;
    tick;
    xp_ready = 0; abort = 0;
    n_tests++;
    if ({busy, xp_valid, act_ready, env_en, env_rst, step_cnt, ep_cnt, env_mode} !== 8'b00000001) begin n_fail++; $display("FAIL abort_handshake got=%b want=00000001", {busy, xp_valid, act_ready, env_en, env_rst, step_cnt, ep_cnt, env_mode}); end
  endtask
  task automatic test_wrap;
    int n_tup, n_en;
    bit hs_prev, both, exp_rst;
    n_tup = 0; n_en = 0; hs_prev = 0; both = 0;
    cfg_mode = 0; start = 1;
    tick;
    start = 0; act_valid = 1; xp_ready = 1;
    for (int c = 0; c < 200; c++) begin
      exp_rst = c == 0 || (hs_prev && n_tup == 2);
      n_tests++;
      if (env_rst !== exp_rst) begin n_fail++; $display("FAIL wrap_env_rst cyc=%0d got=%b want=%b", c, env_rst, exp_rst); end
      if (env_en) n_en++;
      if (env_en && env_rst) both = 1;
      if (done) break;
      hs_prev = xp_valid;
      if (xp_valid) begin
        n_tests++;
        if (xp_last !== (n_tup % 2 == 1)) begin n_fail++; $display("FAIL wrap_xp_last tuple=%0d got=%b", n_tup, xp_last); end
        n_tup++;
      end
      act_data = 4'($urandom); env_S = 8'($urandom); env_R = 16'($urandom);
      tick;
    end
    act_valid = 0; xp_ready = 0;
    n_tests++;
    if (!(done === 1'b1 && hs_prev && n_tup == 4)) begin n_fail++; $display("FAIL wrap_done got=done:%b tuples:%0d want=done:1 tuples:4", done, n_tup); end
    n_tests++;
    if (n_en != 4 || both) begin n_fail++; $display("FAIL wrap_env_en got=%0d overlap=%b want=4 overlap=0", n_en, both); end
    n_tests++;
    if ({step_cnt, ep_cnt, busy, act_ready} !== 4'b1100) begin n_fail++; $display("FAIL wrap_final got=%b want=1100", {step_cnt, ep_cnt, busy, act_ready}); end
  endtask
  task automatic test_random(input int runs);
    logic [S-1:0] sh [0:511];
    logic [R-1:0] rh [0:511];
    logic [A-1:0] ta;
    logic [S-1:0] ts;
    int k, hs, rst_due, mstep, mep;
    bit inflight, active, tl, m_mode, exp_xpv, exp_ready;
    for (int r = 0; r < runs; r++) begin
      m_mode = 1'($urandom); cfg_mode = m_mode; start = 1;
      tick;
      start = 0;
      k = 0; hs = -100; rst_due = 0; mstep = 0; mep = 0; inflight = 0; active = 1; tl = 0; ta = '0; ts = '0;
      while (active && k < 400) begin
        exp_xpv = inflight && k >= hs + H + 3;
        exp_ready = !inflight;
        n_tests++;
        if ({act_ready, env_en, env_rst, xp_valid, busy, done, env_mode} !== {exp_ready, k == hs + 1, k == rst_due, exp_xpv, 2'b10, m_mode})
          begin n_fail++; $display("FAIL random_ctrl run=%0d cyc=%0d got=%b want=%b", r, k, {act_ready, env_en, env_rst, xp_valid, busy, done, env_mode}, {exp_ready, k == hs + 1, k == rst_due, exp_xpv, 2'b10, m_mode}); end
        n_tests++;
        if ({step_cnt, ep_cnt} !== {1'(mstep), 1'(mep)}) begin n_fail++; $display("FAIL random_counters run=%0d cyc=%0d got=%b want=%b", r, k, {step_cnt, ep_cnt}, {1'(mstep), 1'(mep)}); end
        if (k > hs && hs >= 0) begin
          n_tests++;
          if (env_A !== ta) begin n_fail++; $display("FAIL random_env_A run=%0d cyc=%0d got=%h want=%h", r, k, env_A, ta); end
        end
        if (exp_xpv) begin
          n_tests++;
          if ({xp_s, xp_a, xp_r, xp_s_next, xp_last} !== {ts, ta, rh[hs+H+2], sh[hs+H+2], tl})
            begin n_fail++; $display("FAIL random_tuple run=%0d cyc=%0d got=%h want=%h", r, k, {xp_s, xp_a, xp_r, xp_s_next, xp_last}, {ts, ta, rh[hs+H+2], sh[hs+H+2], tl}); end
        end
        env_S = 8'($urandom); env_R = 16'($urandom); act_data = 4'($urandom);
        act_valid = ($urandom % 3) != 0; xp_ready = 1'($urandom);
        sh[k] = env_S; rh[k] = env_R;
        if (exp_ready && act_valid) begin
          inflight = 1; hs = k; ta = act_data; ts = env_S; tl = mstep == SM - 1;
        end else if (exp_xpv && xp_ready) begin
          inflight = 0;
          if (!tl) mstep++;
          else if (mep == EM - 1) active = 0;
          else begin mstep = 0; mep++; rst_due = k + 1; end
        end
        tick;
        k++;
      end
      act_valid = 0; xp_ready = 0;
      n_tests++;
      if (active || {done, busy, act_ready, xp_valid, step_cnt, ep_cnt} !== 6'b100011)
        begin n_fail++; $display("FAIL random_end run=%0d timeout=%b got=%b want=100011", r, active, {done, busy, act_ready, xp_valid, step_cnt, ep_cnt}); end
    end
  endtask
  task automatic test_rst_mid;
    cfg_mode = 1; start = 1;
    tick;
    start = 0; act_valid = 1; act_data = 4'($urandom); env_S = 8'($urandom); env_R = 16'($urandom);
    tick;
    act_valid = 0;
    for (int i = 0; i < 20 && !xp_valid; i++) tick;
    n_tests++;
    if (xp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach_publish got=%b want=1", xp_valid); end
    rst = 1;
    tick;
    rst = 0;
    n_tests++;
    if (outs() !== 64'd0) begin n_fail++; $display("FAIL rst_mid_outputs got=%h want=0", outs()); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_tests++;
      if ({env_rst, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_no_pulse cyc=%0d got=%b want=00", i, {env_rst, busy}); end
    end
    cfg_mode = 1; start = 1;
    tick;
    start = 0;
    n_tests++;
    if ({env_rst, env_mode, step_cnt, ep_cnt, act_ready} !== 5'b11001) begin n_fail++; $display("FAIL rst_mid_restart got=%b want=11001", {env_rst, env_mode, step_cnt, ep_cnt, act_ready}); end
  endtask
  initial begin
    test_reset;
    test_nominal;
    test_backpressure;
    test_stall;
    test_abort;
    test_wrap;
    test_random(4);
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
